// File: rtl/and_gate_exerciser.sv
// Clocked sweep engine for a combinational AND gate: drives every input vector in
// ascending order, samples the response after a settle time and tallies mismatches.
module and_gate_exerciser #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            r,
  output logic [N_IN-1:0] in_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic exp_and(input logic [N_IN-1:0] v);
    return &v;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [3:0]      settle_cnt_r, settle_cnt_nxt_s;
  logic [N_IN-1:0] in_vec_nxt_s, first_fail_nxt_s;
  logic [N_IN:0]   err_cnt_nxt_s, err_inc_s;
  logic            busy_nxt_s, done_nxt_s, pass_nxt_s, first_fail_vld_nxt_s;
  logic            start_ok_s, last_settle_s, mismatch_s;

  assign start_ok_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_settle_s = (settle_cnt_r == 4'(SETTLE - 1));
  assign mismatch_s    = (state_r == ST_CHECK) && (r != exp_and(in_vec));
  assign err_inc_s     = err_cnt + (N_IN + 1)'(mismatch_s);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) state_nxt_s = ST_DRIVE;
        else            state_nxt_s = state_r;
      end
      ST_DRIVE: begin
        if (last_settle_s) state_nxt_s = ST_CHECK;
        else               state_nxt_s = ST_DRIVE;
      end
      ST_CHECK: begin
        if (&in_vec) state_nxt_s = ST_DONE;
        else         state_nxt_s = ST_DRIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and settle counter
  always_comb begin
    in_vec_nxt_s         = in_vec;
    busy_nxt_s           = busy;
    done_nxt_s           = done;
    pass_nxt_s           = pass;
    err_cnt_nxt_s        = err_cnt;
    first_fail_nxt_s     = first_fail;
    first_fail_vld_nxt_s = first_fail_vld;
    settle_cnt_nxt_s     = settle_cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          in_vec_nxt_s         = '0;
          busy_nxt_s           = 1'b1;
          done_nxt_s           = 1'b0;
          pass_nxt_s           = 1'b0;
          err_cnt_nxt_s        = '0;
          first_fail_nxt_s     = '0;
          first_fail_vld_nxt_s = 1'b0;
          settle_cnt_nxt_s     = 4'd0;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r;
        end
      end
      ST_DRIVE: begin
        if (last_settle_s) settle_cnt_nxt_s = 4'd0;
        else               settle_cnt_nxt_s = settle_cnt_r + 4'd1;
      end
      ST_CHECK: begin
        err_cnt_nxt_s = err_inc_s;
        // Only the first mismatch of a sweep is captured
        if (mismatch_s && !first_fail_vld) begin
          first_fail_nxt_s     = in_vec;
          first_fail_vld_nxt_s = 1'b1;
        end else begin
          first_fail_vld_nxt_s = first_fail_vld;
        end
        if (&in_vec) begin
          busy_nxt_s = 1'b0;
          done_nxt_s = 1'b1;
          pass_nxt_s = (err_inc_s == '0);
        end else begin
          in_vec_nxt_s = in_vec + N_IN'(1);
        end
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vec         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      settle_cnt_r   <= 4'd0;
    end else begin
      in_vec         <= in_vec_nxt_s;
      busy           <= busy_nxt_s;
      done           <= done_nxt_s;
      pass           <= pass_nxt_s;
      err_cnt        <= err_cnt_nxt_s;
      first_fail     <= first_fail_nxt_s;
      first_fail_vld <= first_fail_vld_nxt_s;
      settle_cnt_r   <= settle_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_and_gate_exerciser.sv
// Scoreboard bench: two exercisers (settle 1 and 3) driving a truth-table stand-in
// for the gate under test; expected sweep results come from a table-level model.
module tb_and_gate_exerciser;

  typedef struct packed {
    logic [2:0] err;
    logic [1:0] ff;
    logic       vld;
    logic       pss;
  } exp_t;

  localparam int SET0 = 1;
  localparam int SET1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_s, start_s, r_s, busy_s, done_s, pass_s, vld_s;
  logic [1:0][1:0] in_vec_s, ff_s;
  logic [1:0][2:0] err_s;
  logic [1:0][3:0] tbl_r;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   timeouts = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  assign r_s[0] = tbl_r[0][in_vec_s[0]];
  assign r_s[1] = tbl_r[1][in_vec_s[1]];

  and_gate_exerciser #(.N_IN(2), .SETTLE(SET0)) u_ex0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .r(r_s[0]),
    .in_vec(in_vec_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_cnt(err_s[0]), .first_fail(ff_s[0]), .first_fail_vld(vld_s[0])
  );

  and_gate_exerciser #(.N_IN(2), .SETTLE(SET1)) u_ex1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .r(r_s[1]),
    .in_vec(in_vec_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_cnt(err_s[1]), .first_fail(ff_s[1]), .first_fail_vld(vld_s[1])
  );

  // Reference: the correct response is 1 only for the all-ones vector
  function automatic exp_t model(input logic [3:0] tbl);
    exp_t e;
    e = '0;
    for (int v = 0; v < 4; v++) begin
      if (tbl[v] != (v == 3)) begin
        e.err = e.err + 3'd1;
        if (!e.vld) begin
          e.ff  = 2'(v);
          e.vld = 1'b1;
        end
      end
    end
    e.pss = (e.err == 3'd0);
    return e;
  endfunction

  task automatic check(input string nm, input int g, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle in_vec tracking, reset checks, result pop on done rise
  logic [1:0] busy_prev = 2'b00, done_prev = 2'b00, rst_pend = 2'b00;
  int cyc [2] = '{0, 0};
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int   s;
      exp_t e;
      s = (g == 0) ? SET0 : SET1;
      if (rst_pend[g]) begin
        check("reset_outputs", g,
              int'({in_vec_s[g], busy_s[g], done_s[g], pass_s[g], err_s[g], ff_s[g], vld_s[g]}), 0);
        cyc[g] = 0;
        if (g == 0) q0.delete();
        else        q1.delete();
      end else begin
        if (busy_s[g] && !busy_prev[g]) begin
          cyc[g] = 0;
          check("start_clears", g,
                int'({done_s[g], pass_s[g], err_s[g], ff_s[g], vld_s[g]}), 0);
        end
        if (busy_s[g]) begin
          check("in_vec", g, int'(in_vec_s[g]), cyc[g] / (s + 1));
          cyc[g]++;
        end
        if (done_s[g] && !done_prev[g]) begin
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            check("unexpected_done", g, 1, 0);
          end else begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            check("sweep_cycles", g, cyc[g], 4 * (s + 1));
            check("busy_at_done", g, int'(busy_s[g]), 0);
            check("err_cnt", g, int'(err_s[g]), int'(e.err));
            check("first_fail_vld", g, int'(vld_s[g]), int'(e.vld));
            if (e.vld) check("first_fail", g, int'(ff_s[g]), int'(e.ff));
            check("pass", g, int'(pass_s[g]), int'(e.pss));
          end
        end
      end
      busy_prev[g] = busy_s[g];
      done_prev[g] = done_s[g];
      rst_pend[g]  = rst_s[g];
    end
    if (final_req && !final_done) begin
      check("pending_q0", 0, q0.size(), 0);
      check("pending_q1", 1, q1.size(), 0);
      check("timeouts", 0, timeouts, 0);
      final_done = 1'b1;
    end
  end

  task automatic run(input int g, input logic [3:0] tbl, input bit extra);
    @(posedge clk); #1;
    tbl_r[g]   = tbl;
    start_s[g] = 1'b1;
    if (g == 0) q0.push_back(model(tbl));
    else        q1.push_back(model(tbl));
    @(posedge clk); #1;
    start_s[g] = 1'b0;
    if (extra) begin
      repeat (2) @(posedge clk);
      #1 start_s[g] = 1'b1;
      @(posedge clk); #1;
      start_s[g] = 1'b0;
    end
    for (int k = 0; k < 200 && !done_s[g]; k++) @(posedge clk);
    if (!done_s[g]) timeouts++;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid(input int g);
    @(posedge clk); #1;
    tbl_r[g]   = 4'b1000;
    start_s[g] = 1'b1;
    @(posedge clk); #1;
    start_s[g] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_s[g] = 1'b1;
    @(posedge clk); #1;
    rst_s[g] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_s   = 2'b11;
    start_s = 2'b00;
    tbl_r[0] = 4'b1000;
    tbl_r[1] = 4'b1000;
    repeat (3) @(posedge clk);
    #1 rst_s = 2'b00;
    run(0, 4'b1000, 1'b0);
    run(0, 4'b1111, 1'b0);
    run(0, 4'b1110, 1'b0);
    run(0, 4'b1000, 1'b0);
    run(0, 4'b1000, 1'b1);
    for (int i = 0; i < 8; i++) run(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    reset_mid(0);
    run(0, 4'b1110, 1'b0);
    reset_mid(1);
    run(1, 4'b1000, 1'b0);
    run(1, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) run(1, 4'($urandom_range(0, 15)), 1'b0);
    final_req = 1'b1;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
